// File: rtl/icn2038s_pkg.sv
// Shared constants and types for the ICN2038S receive-side command decoder.
package icn2038s_pkg;

  localparam int unsigned REG_W = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] CNT_ONE      = 5'd1;
  localparam logic [CNT_W-1:0] CNT_MAX      = 5'd31;
  localparam logic [CNT_W-1:0] LATCH_PULSES = 5'd3;
  localparam logic [CNT_W-1:0] REG1_PULSES  = 5'd11;
  localparam logic [CNT_W-1:0] REG2_PULSES  = 5'd12;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LATCH = 2'd1,
    CMD_REG1  = 2'd2,
    CMD_REG2  = 2'd3
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DECODE
  } state_e;

endpackage

// File: rtl/icn_sync_edge.sv
// Multi-flop input synchronizer with registered rise/fall pulses aligned to the synced output.
module icn_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    // Compare the stage about to reach the output with the output itself, so the
    // pulse is high in exactly the cycle where s first shows the new level.
    rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/icn2038s_cmd_decoder.sv
// ICN2038S command decoder: counts DCLK rises inside each LE window and applies
// DATA_LATCH / WR_REG1 / WR_REG2. Define ICN_CMD_ERR_EN to report unknown commands.
module icn2038s_cmd_decoder
  import icn2038s_pkg::*;
#(
  parameter int unsigned CHANNELS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdi_in,
  input  logic                dclk_in,
  input  logic                le_in,
  input  logic                oe_in,
  output logic [CHANNELS-1:0] ch_out,
  output logic [REG_W-1:0]    reg1_q,
  output logic [REG_W-1:0]    reg2_q,
  output logic                cmd_valid,
  output logic [1:0]          cmd_code,
  output logic                err_unknown,
  output logic [ERR_W-1:0]    err_count
);

  logic dclk_s, dclk_rise, dclk_fall;
  logic le_s, le_rise, le_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic oe_s, oe_rise, oe_fall;
  logic unused_edges;

  icn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dclk (
    .clk(clk), .rst_n(rst_n), .d(dclk_in), .s(dclk_s), .rise(dclk_rise), .fall(dclk_fall));
  icn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .d(le_in), .s(le_s), .rise(le_rise), .fall(le_fall));
  icn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(sdi_in), .s(sdi_s), .rise(sdi_rise), .fall(sdi_fall));
  icn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(clk), .rst_n(rst_n), .d(oe_in), .s(oe_s), .rise(oe_rise), .fall(oe_fall));

  assign unused_edges = ^{dclk_s, dclk_fall, le_s, sdi_rise, sdi_fall, oe_rise, oe_fall};

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] shift_q, shift_d;
  logic [CHANNELS-1:0] out_latch_q, out_latch_d;
  logic [CHANNELS-1:0] ch_out_q, ch_out_d;
  logic [CNT_W-1:0]    pulse_cnt_q, pulse_cnt_d, cnt_sat;
  logic [REG_W-1:0]    reg1_d, reg2_d;
  logic                cmd_valid_q, cmd_valid_d;
  cmd_code_e           cmd_code_q, cmd_code_d;
  logic                decode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (le_rise) state_d = ST_CMD;
      ST_CMD:    if (le_fall) state_d = ST_DECODE;
      ST_DECODE: state_d = le_rise ? ST_CMD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Decode acts on the CMD->DECODE transition using the next-cycle shift/count,
  // so a DCLK rise coinciding with the LE fall is included.
  always_comb begin
    shift_d = shift_q;
    if (dclk_rise) shift_d = {shift_q[CHANNELS-2:0], sdi_s};

    cnt_sat = (pulse_cnt_q == CNT_MAX) ? pulse_cnt_q : pulse_cnt_q + 1'b1;
    if (state_q == ST_CMD) pulse_cnt_d = dclk_rise ? cnt_sat : pulse_cnt_q;
    else                   pulse_cnt_d = (le_rise && dclk_rise) ? CNT_ONE : '0;

    decode      = (state_q == ST_CMD) && le_fall;
    out_latch_d = out_latch_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    if (decode) begin
      case (pulse_cnt_d)
        LATCH_PULSES: begin
          out_latch_d = shift_d;
          cmd_valid_d = 1'b1;
          cmd_code_d  = CMD_LATCH;
        end
        REG1_PULSES: begin
          reg1_d      = shift_d[REG_W-1:0];
          cmd_valid_d = 1'b1;
          cmd_code_d  = CMD_REG1;
        end
        REG2_PULSES: begin
          reg2_d      = shift_d[REG_W-1:0];
          cmd_valid_d = 1'b1;
          cmd_code_d  = CMD_REG2;
        end
        default: ;
      endcase
    end

    ch_out_d = out_latch_d & {CHANNELS{~oe_s}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      pulse_cnt_q <= '0;
      out_latch_q <= '0;
      ch_out_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
    end else begin
      shift_q     <= shift_d;
      pulse_cnt_q <= pulse_cnt_d;
      out_latch_q <= out_latch_d;
      ch_out_q    <= ch_out_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign ch_out    = ch_out_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;

`ifdef ICN_CMD_ERR_EN
  logic             err_unknown_q, err_unknown_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_unknown_d = decode && (pulse_cnt_d != '0) && (pulse_cnt_d != LATCH_PULSES) &&
                    (pulse_cnt_d != REG1_PULSES) && (pulse_cnt_d != REG2_PULSES);
    err_count_d = err_count_q;
    if (err_unknown_d && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unknown_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      err_unknown_q <= err_unknown_d;
      err_count_q   <= err_count_d;
    end
  end

  assign err_unknown = err_unknown_q;
  assign err_count   = err_count_q;
`else
  assign err_unknown = 1'b0;
  assign err_count   = '0;
`endif

endmodule
